instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   Initiator side of the instruction-memory interface for the GPP.
//   - Load phase: drives read_file until the memory reports fin_file, and counts the loaded lines.
//   - Fetch phase: drives read_memory/pos and captures the returned instruction.
//   - Hands each instruction to the decoder over a valid/ready handshake.
//   - Applies branch redirects from the execute stage.
// PARAMETERS
//   ADDR_W     9    width of pos / program counter
//   INSTR_W    16   instruction width
//   MEM_DEPTH  400  instruction memory capacity (lines)
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        synchronous, active-high reset
//   start          in   1        1-cycle pulse in IDLE: begin loading
//   fin_file       in   1        memory: last file line stored
//   read_file      out  1        memory: store next file line this edge
//   read_memory    out  1        memory: read line at pos this edge
//   pos            out  ADDR_W   memory read address (= pc)
//   mem_instr      in   INSTR_W  memory return line, valid the cycle after a read edge
//   instr_out      out  INSTR_W  instruction to decoder
//   instr_pc       out  ADDR_W   address of instr_out
//   instr_valid    out  1        instr_out valid
//   instr_ready    in   1        decoder accepts (handshake = valid & ready)
//   branch_valid   in   1        redirect; sampled only on a handshake edge
//   branch_target  in   ADDR_W   absolute redirect address
//   prog_len       out  ADDR_W   number of lines loaded
//   done           out  1        sticky: program finished
//   overflow       out  1        sticky: load hit MEM_DEPTH without fin_file
//   err            out  1        sticky: branch_target >= prog_len
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 (read_file, read_memory, pos, instr_out, instr_pc,
//     instr_valid, prog_len, done, overflow, err). Reset has priority over every other input.
//     A mid-load reset does not rewind the memory; the memory must be reset with this block.
//   States: IDLE, LOAD, FETCH, CAPTURE, HOLD, DONE.
//   IDLE: start=1 -> LOAD. start is ignored in every other state.
//   LOAD:
//     - read_file = (state==LOAD) & ~fin_file (combinational), so there is no extra read after fin_file.
//     - Every edge with read_file=1: prog_len += 1.
//     - fin_file=1 -> FETCH with pc=0, or DONE if prog_len==0.
//     - prog_len reaching MEM_DEPTH with fin_file=0 -> overflow=1, read_file drops, -> FETCH.
//   FETCH: read_memory=1 (combinational), pos=pc; -> CAPTURE next edge.
//   CAPTURE: read_memory=0. At this edge: instr_out<=mem_instr, instr_pc<=pc, instr_valid<=1; -> HOLD.
//   HOLD:
//     - instr_out, instr_pc and instr_valid are held stable until the handshake; pos is unchanged.
//     - On handshake: instr_valid<=0.
//       - branch_valid=1 and target<prog_len: pc<=target -> FETCH.
//       - branch_valid=1 and target>=prog_len: err=1 -> DONE.
//       - otherwise pc+1<prog_len: pc<=pc+1 -> FETCH.
//       - otherwise: -> DONE.
//   DONE: done=1; read_file=read_memory=instr_valid=0; remains until rst.
//   Latency: handshake at edge k -> read edge k+1 -> instr_valid high after edge k+2.
//     Peak throughput is 1 instruction per 3 cycles.
//   Width: pc+1 is computed in ADDR_W+1 bits; no wrap is possible since prog_len <= MEM_DEPTH.
// TESTING
//   1. 3-line file, start pulse -> read_file high exactly 3 cycles, prog_len=3;
//      instr_pc 0,1,2 emitted in order with file contents, ready held high; then done=1.
//   2. Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_out/instr_pc/valid stable,
//      read_memory=0, pos unchanged; ready=1 -> next instr_pc=pc+1.
//   3. Branch: prog_len=5, handshake at pc=3 with branch_valid=1, target=1 -> next instr_pc=1, err=0.
//   4. Bad branch: prog_len=5, target=7 on handshake -> err=1, done=1, no further read_memory.
//   5. Overflow: MEM_DEPTH=4, fin_file held 0 -> read_file high 4 cycles, overflow=1, prog_len=4,
//      fetch starts at pc=0.
//   6. rst=1 during HOLD -> after that edge all outputs 0, state IDLE; start is required to resume.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads the program file into memory,
// then fetches, hands off to decode and follows branch redirects.
module instr_fetch_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int INSTR_W   = 16,
  parameter int MEM_DEPTH = 400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               fin_file,
  output logic               read_file,
  output logic               read_memory,
  output logic [ADDR_W-1:0]  pos,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  prog_len,
  output logic               done,
  output logic               overflow,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FETCH, CAPTURE, HOLD, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  state_t            next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   pc_inc;
  logic              hs;
  logic              br_ok;
  logic              seq_ok;
  logic              full;

  assign pos    = pc;
  assign done   = (state == DONE);
  assign hs     = (state == HOLD) & instr_valid & instr_ready;
  assign br_ok  = branch_target < prog_len;
  assign pc_inc = {1'b0, pc} + (ADDR_W+1)'(1);
  assign seq_ok = pc_inc < {1'b0, prog_len};
  assign full   = (prog_len == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // next-state and memory strobes
  always_comb begin
    next        = state;
    read_file   = 1'b0;
    read_memory = 1'b0;
    unique case (state)
      IDLE: if (start) next = LOAD;
      LOAD: begin
        read_file = ~fin_file;
        if (fin_file)
          next = (prog_len == '0) ? DONE : FETCH;
        else if (full)
          next = FETCH;
      end
      FETCH: begin
        read_memory = 1'b1;
        next        = CAPTURE;
      end
      CAPTURE: next = HOLD;
      HOLD: begin
        if (hs) begin
          if (branch_valid)
            next = br_ok ? FETCH : DONE;
          else
            next = seq_ok ? FETCH : DONE;
        end
      end
      DONE: next = DONE;
      default: next = IDLE;
    endcase
  end

  // load counter, pc, decode hand-off and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      prog_len    <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      overflow    <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (state == LOAD) begin
        if (fin_file) begin
          pc <= '0;
        end else begin
          prog_len <= prog_len + ADDR_W'(1);
          if (full) begin
            overflow <= 1'b1;
            pc       <= '0;
          end
        end
      end
      if (state == CAPTURE) begin
        instr_out   <= mem_instr;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      if (hs) begin
        instr_valid <= 1'b0;
        if (branch_valid) begin
          if (br_ok) pc  <= branch_target;
          else       err <= 1'b1;
        end else if (seq_ok) begin
          pc <= pc_inc[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: file/memory model plus a
// scoreboard of expected (pc, instruction) hand-offs.
module tb_instr_fetch_ctrl;

  localparam int AW = 9;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start2;
  logic          fin_file;
  logic          read_file;
  logic          read_memory;
  logic [AW-1:0] pos;
  logic [IW-1:0] mem_instr;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] prog_len;
  logic          done;
  logic          overflow;
  logic          err;

  logic          fin0;
  logic [IW-1:0] mem0;
  logic          read_file2;
  logic          read_memory2;
  logic [AW-1:0] pos2;
  logic [IW-1:0] instr_out2;
  logic [AW-1:0] instr_pc2;
  logic          instr_valid2;
  logic [AW-1:0] prog_len2;
  logic          done2;
  logic          overflow2;
  logic          err2;

  assign fin0 = 1'b0;
  assign mem0 = '0;

  always #5 clk = ~clk;

  instr_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .fin_file(fin_file), .read_file(read_file),
    .read_memory(read_memory), .pos(pos),
    .mem_instr(mem_instr), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .prog_len(prog_len), .done(done),
    .overflow(overflow), .err(err)
  );

  instr_fetch_ctrl #(.MEM_DEPTH(4)) u_ovf (
    .clk(clk), .rst(rst), .start(start2),
    .fin_file(fin0), .read_file(read_file2),
    .read_memory(read_memory2), .pos(pos2),
    .mem_instr(mem0), .instr_out(instr_out2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .prog_len(prog_len2), .done(done2),
    .overflow(overflow2), .err(err2)
  );

  logic [IW-1:0] file_mem [0:15];
  logic [IW-1:0] mem      [0:15];
  logic [AW-1:0] file_len;
  logic [AW-1:0] wr_idx;

  assign fin_file = (wr_idx == file_len);

  // memory model: file store and registered read port
  always @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
    end else if (read_file) begin
      mem[wr_idx[3:0]] <= file_mem[wr_idx[3:0]];
      wr_idx <= wr_idx + AW'(1);
    end
    if (read_memory) mem_instr <= mem[pos[3:0]];
  end

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } exp_t;

  exp_t q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare each hand-off before its edge
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 32'(q.size()), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        chk("sb_ins", 32'(instr_out), 32'(e.ins));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_file(input int n, input int base);
    for (int i = 0; i < 16; i++)
      file_mem[i] = (i < n) ? IW'(base + i) : '0;
    file_len = AW'(n);
  endtask

  task automatic push_seq(input int pc0, input int n);
    for (int i = pc0; i < n; i++)
      q.push_back('{pc: AW'(i), ins: file_mem[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int rf);
    rf = 0;
    for (int i = 0; i < budget && !done; i++) begin
      rf += int'(read_file);
      tick();
    end
    chk("done", 32'(done), 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !instr_valid; i++)
      tick();
    chk("valid", 32'(instr_valid), 1);
  endtask

  task automatic run_branch(input int at_pc,
                            input int tgt,
                            input int budget);
    bit br;
    br = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      branch_valid = 1'b0;
      if (instr_valid && instr_pc == AW'(at_pc) && !br) begin
        branch_valid  = 1'b1;
        branch_target = AW'(tgt);
        br = 1'b1;
      end
      tick();
    end
    branch_valid = 1'b0;
    chk("br_done", 32'(done), 1);
  endtask

  int            rf;
  int            acc;
  logic [AW-1:0] h_pc;
  logic [AW-1:0] h_pos;
  logic [IW-1:0] h_ins;
  bit            seen;
  logic [AW-1:0] fpos;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    instr_ready = 1'b0;
    branch_valid = 1'b0;
    branch_target = '0;
    load_file(0, 0);
    tick();
    do_reset();

    // reset state
    chk("rst_ctl", 32'({read_file, read_memory,
        instr_valid, done, overflow, err}), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_ins", 32'(instr_out), 0);
    chk("rst_len", 32'(prog_len), 0);
    chk("rst_ovf2", 32'({overflow2, done2}), 0);

    // 3-line program, ready held high
    load_file(3, 'hA0);
    instr_ready = 1'b1;
    push_seq(0, 3);
    pulse_start();
    run_to_done(60, rf);
    chk("t1_rf", 32'(rf), 3);
    chk("t1_len", 32'(prog_len), 3);
    chk("t1_sb", 32'(q.size()), 0);
    chk("t1_err", 32'(err), 0);

    // backpressure then branch 3 -> 1
    do_reset();
    load_file(5, 'hB0);
    instr_ready = 1'b0;
    push_seq(0, 4);
    push_seq(1, 5);
    pulse_start();
    wait_valid(40);
    h_pc = instr_pc;
    h_ins = instr_out;
    h_pos = pos;
    chk("bp_first", 32'(h_pc), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pc", 32'(instr_pc), 32'(h_pc));
      chk("bp_ins", 32'(instr_out), 32'(h_ins));
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_rdmem", 32'(read_memory), 0);
      chk("bp_pos", 32'(pos), 32'(h_pos));
    end
    instr_ready = 1'b1;
    run_branch(3, 1, 120);
    chk("br_err", 32'(err), 0);
    chk("br_len", 32'(prog_len), 5);
    chk("br_sb", 32'(q.size()), 0);

    // out-of-range branch
    do_reset();
    load_file(5, 'hC0);
    push_seq(0, 3);
    pulse_start();
    run_branch(2, 7, 120);
    chk("bad_err", 32'(err), 1);
    chk("bad_sb", 32'(q.size()), 0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      acc += int'(read_memory) + int'(instr_valid);
      tick();
    end
    chk("bad_quiet", 32'(acc), 0);

    // empty file goes straight to DONE
    do_reset();
    load_file(0, 0);
    pulse_start();
    run_to_done(10, rf);
    chk("empty_rf", 32'(rf), 0);
    chk("empty_len", 32'(prog_len), 0);

    // overflow on a depth-4 instance
    do_reset();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    rf = 0;
    seen = 1'b0;
    fpos = '1;
    for (int i = 0; i < 20; i++) begin
      rf += int'(read_file2);
      if (read_memory2 && !seen) begin
        seen = 1'b1;
        fpos = pos2;
      end
      tick();
    end
    chk("ovf_rf", 32'(rf), 4);
    chk("ovf_flag", 32'(overflow2), 1);
    chk("ovf_len", 32'(prog_len2), 4);
    chk("ovf_fetch", 32'(seen), 1);
    chk("ovf_pos", 32'(fpos), 0);
    chk("ovf_main", 32'(overflow), 0);

    // reset while holding an instruction
    do_reset();
    load_file(3, 'hD0);
    instr_ready = 1'b0;
    pulse_start();
    wait_valid(40);
    do_reset();
    chk("hr_ctl", 32'({read_file, read_memory,
        instr_valid, done, overflow, err}), 0);
    chk("hr_pos", 32'(pos), 0);
    chk("hr_pc", 32'(instr_pc), 0);
    chk("hr_ins", 32'(instr_out), 0);
    chk("hr_len", 32'(prog_len), 0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc += int'(read_file) + int'(read_memory)
           + int'(instr_valid) + int'(done);
    end
    chk("hr_idle", 32'(acc), 0);
    instr_ready = 1'b1;
    push_seq(0, 3);
    pulse_start();
    run_to_done(60, rf);
    chk("hr_rf", 32'(rf), 3);
    chk("hr_sb", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
